// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the control sequencer.
//   - ALU operation encodings driven on alu_op
//   - instruction opcodes (instr[7:4])
//   - FSM state encoding
//   - B-bus source indices and C-bus write-enable bit positions
package ctrl_pkg;

    // ALU operation select
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_PASS = 3'd2;
    localparam logic [2:0] ALU_ZER  = 3'd3;
    localparam logic [2:0] ALU_MUL4 = 3'd5;
    localparam logic [2:0] ALU_DIV2 = 3'd6;

    // Opcodes; 11..14 are unassigned and fall through as NOP
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MOV   = 4'd5;
    localparam logic [3:0] OP_CLR   = 4'd6;
    localparam logic [3:0] OP_MUL4  = 4'd7;
    localparam logic [3:0] OP_DIV2  = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JMPNZ = 4'd10;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FWAIT,
        ST_DECODE,
        ST_EXEC,
        ST_EXEC2,
        ST_MWAIT,
        ST_WB,
        ST_DONE
    } state_t;

    // B-bus sources above the general registers (0..7 = R0..R7)
    localparam logic [3:0] BSEL_MDR = 4'd8;
    localparam logic [3:0] BSEL_AC  = 4'd9;
    localparam logic [3:0] BSEL_PC  = 4'd10;

    // C-bus write enables (bits 0..7 = R0..R7)
    localparam int CWE_W   = 11;
    localparam int CWE_AC  = 8;
    localparam int CWE_MAR = 9;
    localparam int CWE_MDR = 10;

    // One-hot C-bus write enable for destination index idx
    function automatic logic [CWE_W-1:0] cwe_bit(input int idx);
        return {{(CWE_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational control-word decoder.
// Inputs : state_i (FSM state), opcode_i / operand_i (latched instruction
//          fields), z_i (saved zero flag), mem_ready_i (memory handshake).
// Outputs: alu_op_o, b_sel_o, c_we_o, pc_inc_o, pc_load_o, ir_load_o,
//          mem_rd_o, mem_wr_o, busy_o, done_o.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int GPR_W = 3
) (
    input  state_t            state_i,
    input  logic [3:0]        opcode_i,
    input  logic [GPR_W-1:0]  operand_i,
    input  logic              z_i,
    input  logic              mem_ready_i,
    output logic [2:0]        alu_op_o,
    output logic [3:0]        b_sel_o,
    output logic [CWE_W-1:0]  c_we_o,
    output logic              pc_inc_o,
    output logic              pc_load_o,
    output logic              ir_load_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic              busy_o,
    output logic              done_o
);

    logic [3:0] rn_bsel;

    assign rn_bsel = 4'(operand_i);

    always_comb begin
        alu_op_o  = ALU_ZER;
        b_sel_o   = 4'd0;
        c_we_o    = '0;
        pc_inc_o  = 1'b0;
        pc_load_o = 1'b0;
        ir_load_o = 1'b0;
        mem_rd_o  = 1'b0;
        mem_wr_o  = 1'b0;
        busy_o    = (state_i != ST_IDLE) && (state_i != ST_DONE);
        done_o    = (state_i == ST_DONE);

        case (state_i)
            ST_FETCH: begin
                alu_op_o = ALU_PASS;
                b_sel_o  = BSEL_PC;
                c_we_o   = cwe_bit(CWE_MAR);
            end
            ST_FWAIT: begin
                // Request held steady; IR capture and PC bump only on completion
                mem_rd_o = 1'b1;
                if (mem_ready_i) begin
                    ir_load_o = 1'b1;
                    pc_inc_o  = 1'b1;
                end
            end
            ST_EXEC: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: begin
                        alu_op_o = ALU_PASS;
                        b_sel_o  = rn_bsel;
                        c_we_o   = cwe_bit(CWE_MAR);
                    end
                    OP_ADD: begin
                        alu_op_o = ALU_ADD;
                        b_sel_o  = rn_bsel;
                        c_we_o   = cwe_bit(CWE_AC);
                    end
                    OP_SUB: begin
                        alu_op_o = ALU_SUB;
                        b_sel_o  = rn_bsel;
                        c_we_o   = cwe_bit(CWE_AC);
                    end
                    OP_MOV: begin
                        alu_op_o = ALU_PASS;
                        b_sel_o  = BSEL_AC;
                        c_we_o   = cwe_bit(int'(operand_i));
                    end
                    OP_CLR: begin
                        alu_op_o = ALU_ZER;
                        c_we_o   = cwe_bit(CWE_AC);
                    end
                    OP_MUL4: begin
                        alu_op_o = ALU_MUL4;
                        c_we_o   = cwe_bit(CWE_AC);
                    end
                    OP_DIV2: begin
                        alu_op_o = ALU_DIV2;
                        c_we_o   = cwe_bit(CWE_AC);
                    end
                    OP_JMP: begin
                        alu_op_o  = ALU_PASS;
                        b_sel_o   = rn_bsel;
                        pc_load_o = 1'b1;
                    end
                    OP_JMPNZ: begin
                        if (!z_i) begin
                            alu_op_o  = ALU_PASS;
                            b_sel_o   = rn_bsel;
                            pc_load_o = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                alu_op_o = ALU_PASS;
                b_sel_o  = BSEL_AC;
                c_we_o   = cwe_bit(CWE_MDR);
            end
            ST_MWAIT: begin
                // Only LOAD and STORE reach MWAIT
                if (opcode_i == OP_LOAD) begin
                    mem_rd_o = 1'b1;
                end else begin
                    mem_wr_o = 1'b1;
                end
            end
            ST_WB: begin
                alu_op_o = ALU_PASS;
                b_sel_o  = BSEL_MDR;
                c_we_o   = cwe_bit(CWE_AC);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle control sequencer.
// Holds the FSM, the latched opcode/operand and the saved zero flag; the
// control word itself comes from ctrl_decode.
// Ports: clk, rst_n (sync, active-low), start, instr[7:0], mem_ready,
//        flag_z -> alu_op[2:0], b_sel[3:0], c_we[10:0], pc_inc, pc_load,
//        ir_load, mem_rd, mem_wr, busy, done.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int N_GPR = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  instr,
    input  logic        mem_ready,
    input  logic        flag_z,
    output logic [2:0]  alu_op,
    output logic [3:0]  b_sel,
    output logic [10:0] c_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        ir_load,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done
);

    localparam int GPR_W = $clog2(N_GPR);

    state_t            state_q, state_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [GPR_W-1:0]  operand_q, operand_d;
    logic              z_q, z_d;

    // Operand bits above the register index are don't-care
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= OP_NOP;
            operand_q <= '0;
            z_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            z_q       <= z_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        z_d       = z_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_FWAIT;
            ST_FWAIT: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d  = instr[7:4];
                operand_d = instr[GPR_W-1:0];
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                // Zero flag is only meaningful after SUB, so only SUB saves it
                if (opcode_q == OP_SUB) z_d = flag_z;
                case (opcode_q)
                    OP_LOAD:  state_d = ST_MWAIT;
                    OP_STORE: state_d = ST_EXEC2;
                    OP_HALT:  state_d = ST_DONE;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_EXEC2: state_d = ST_MWAIT;
            ST_MWAIT: begin
                if (mem_ready) begin
                    state_d = (opcode_q == OP_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_IDLE;
        endcase
    end

    ctrl_decode #(
        .GPR_W (GPR_W)
    ) u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .operand_i   (operand_q),
        .z_i         (z_q),
        .mem_ready_i (mem_ready),
        .alu_op_o    (alu_op),
        .b_sel_o     (b_sel),
        .c_we_o      (c_we),
        .pc_inc_o    (pc_inc),
        .pc_load_o   (pc_load),
        .ir_load_o   (ir_load),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .busy_o      (busy),
        .done_o      (done)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Outputs are packed into one control word and compared one cycle at a time,
// sampled 1 ns after each rising edge.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  instr;
    logic        mem_ready;
    logic        flag_z;
    logic [2:0]  alu_op;
    logic [3:0]  b_sel;
    logic [10:0] c_we;
    logic        pc_inc;
    logic        pc_load;
    logic        ir_load;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe field order: {pc_inc, pc_load, ir_load, mem_rd, mem_wr}
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_FETCH = 5'b10110;
    localparam logic [4:0] S_RD    = 5'b00010;
    localparam logic [4:0] S_WR    = 5'b00001;
    localparam logic [4:0] S_PCLD  = 5'b01000;

    logic [24:0] cw;
    logic [24:0] e;
    assign cw = {alu_op, b_sel, c_we, pc_inc, pc_load, ir_load, mem_rd, mem_wr, busy, done};

    control_unit #(.N_GPR(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr     (instr),
        .mem_ready (mem_ready),
        .flag_z    (flag_z),
        .alu_op    (alu_op),
        .b_sel     (b_sel),
        .c_we      (c_we),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .ir_load   (ir_load),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] exp_cw(input logic [2:0] a, input logic [3:0] b,
                                           input logic [10:0] c, input logic [4:0] s,
                                           input logic bz, input logic dn);
        return {a, b, c, s, bz, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a FETCH cycle, run a zero-wait fetch and stop in EXEC
    task automatic to_exec(input logic [7:0] ins, input logic fz);
        instr     = ins;
        flag_z    = fz;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; instr = 8'h00; mem_ready = 1'b0; flag_z = 1'b0;
        tick();
        tick();
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b0, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", cw, e); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", cw, e); end
        $display("reset: outputs idle");
    endtask

    task automatic test_add();
        instr = 8'h35; mem_ready = 1'b1; start = 1'b1;
        tick();
        e = exp_cw(3'd2, 4'd10, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL add_fetch: got %h expected %h", cw, e); end
        tick();   // start still high: must be ignored while busy
        e = exp_cw(3'd3, 4'd0, 11'h000, S_FETCH, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL add_fwait: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL add_decode: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd0, 4'd5, 11'h100, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL add_exec: got %h expected %h", cw, e); end
        start = 1'b0;
        tick();
        e = exp_cw(3'd2, 4'd10, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL add_next_fetch: got %h expected %h", cw, e); end
        $display("add 0x35: 4-cycle sequence checked");
    endtask

    task automatic test_sub_jmpnz();
        to_exec(8'h42, 1'b1);
        e = exp_cw(3'd1, 4'd2, 11'h100, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL sub_exec: got %h expected %h", cw, e); end
        tick();
        to_exec(8'hA1, 1'b0);
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL jmpnz_z1_no_jump: got %h expected %h", cw, e); end
        tick();
        to_exec(8'h35, 1'b0);   // ADD with flag_z low must not touch the saved flag
        tick();
        to_exec(8'hA1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL jmpnz_after_add: got %h expected %h", cw, e); end
        tick();
        to_exec(8'h42, 1'b0);
        tick();
        to_exec(8'hA1, 1'b1);
        e = exp_cw(3'd2, 4'd1, 11'h000, S_PCLD, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL jmpnz_jump: got %h expected %h", cw, e); end
        tick();
        $display("sub/jmpnz: branch follows saved zero flag");
    endtask

    task automatic test_single_ops();
        to_exec(8'h96, 1'b0);
        e = exp_cw(3'd2, 4'd6, 11'h000, S_PCLD, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL jmp_exec: got %h expected %h", cw, e); end
        tick();
        to_exec(8'h5B, 1'b0);   // instr[3] ignored: destination R3
        e = exp_cw(3'd2, 4'd9, 11'h008, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL mov_exec: got %h expected %h", cw, e); end
        tick();
        to_exec(8'h60, 1'b0);
        e = exp_cw(3'd3, 4'd0, 11'h100, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL clr_exec: got %h expected %h", cw, e); end
        tick();
        to_exec(8'h70, 1'b0);
        e = exp_cw(3'd5, 4'd0, 11'h100, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL mul4_exec: got %h expected %h", cw, e); end
        tick();
        to_exec(8'h80, 1'b0);
        e = exp_cw(3'd6, 4'd0, 11'h100, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL div2_exec: got %h expected %h", cw, e); end
        tick();
        to_exec(8'hC0, 1'b0);
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL opc_c0_exec: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd2, 4'd10, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL opc_c0_fetch: got %h expected %h", cw, e); end
        $display("single-cycle ops: jmp/mov/clr/mul4/div2/0xC0 checked");
    endtask

    task automatic test_load_wait();
        instr = 8'h13; mem_ready = 1'b1;
        tick();             // FWAIT
        tick();             // DECODE
        mem_ready = 1'b0;
        tick();             // EXEC
        e = exp_cw(3'd2, 4'd3, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL load_exec: got %h expected %h", cw, e); end
        e = exp_cw(3'd3, 4'd0, 11'h000, S_RD, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (cw !== e) begin n_fail++; $display("FAIL load_mwait%0d: got %h expected %h", i, cw, e); end
        end
        mem_ready = 1'b1;   // completes in the third MWAIT cycle
        tick();
        e = exp_cw(3'd2, 4'd8, 11'h100, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL load_wb: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd2, 4'd10, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL load_8cyc_fetch: got %h expected %h", cw, e); end
        $display("load 0x13: 3 wait cycles, 8-cycle sequence checked");
    endtask

    task automatic test_store();
        to_exec(8'h27, 1'b0);
        e = exp_cw(3'd2, 4'd7, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL store_exec: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd2, 4'd9, 11'h400, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL store_exec2: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd3, 4'd0, 11'h000, S_WR, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL store_mwait: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd2, 4'd10, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL store_6cyc_fetch: got %h expected %h", cw, e); end
        $display("store 0x27: exec/exec2/mwait checked");
    endtask

    task automatic test_halt();
        to_exec(8'hF0, 1'b0);
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL halt_exec: got %h expected %h", cw, e); end
        tick();
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b0, 1'b1);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL done_set: got %h expected %h", cw, e); end
        mem_ready = 1'b1;   // ignored outside FWAIT/MWAIT
        tick();
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL done_hold: got %h expected %h", cw, e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        e = exp_cw(3'd2, 4'd10, 11'h200, S_NONE, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL restart_fetch: got %h expected %h", cw, e); end
        $display("halt 0xF0: done held, restart checked");
    endtask

    task automatic test_reset_fwait();
        to_exec(8'h42, 1'b1);   // saved flag becomes 1
        tick();
        instr = 8'hA1; mem_ready = 1'b0;
        tick();
        e = exp_cw(3'd3, 4'd0, 11'h000, S_RD, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL fwait_wait: got %h expected %h", cw, e); end
        tick();
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL fwait_hold: got %h expected %h", cw, e); end
        rst_n = 1'b0;
        tick();
        e = exp_cw(3'd3, 4'd0, 11'h000, S_NONE, 1'b0, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL reset_in_fwait: got %h expected %h", cw, e); end
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        to_exec(8'hA1, 1'b1);
        e = exp_cw(3'd2, 4'd1, 11'h000, S_PCLD, 1'b1, 1'b0);
        n_checks++;
        if (cw !== e) begin n_fail++; $display("FAIL z_cleared_by_reset: got %h expected %h", cw, e); end
        tick();
        $display("reset during FWAIT: idle, mem_rd low, flag cleared");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_jmpnz();
        test_single_ops();
        test_load_wait();
        test_store();
        test_halt();
        test_reset_fwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control sequencer that drives the ALU's operation select and the datapath's bus selects and write enables, and consumes the ALU zero flag for conditional branching. It fetches an 8-bit instruction over a wait-stated memory handshake, decodes it and steps the datapath through execute and memory cycles. It sits between instruction memory, the register file and AC, and the ALU.

## Interface
- `N_GPR`, default 8: general registers R0–R7. Selected by `instr[2:0]`; `instr[3]` is ignored.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: begin execution from the current PC. Honoured only in IDLE or DONE.
- `instr` input, 8 bits: instruction word from the IR. `[7:4]` is the opcode, `[3:0]` the operand register.
- `mem_ready` input, 1 bit: memory completes the current `mem_rd`/`mem_wr` in this cycle.
- `flag_z` input, 1 bit: ALU zero flag.
- `alu_op` output, 3 bits: ADD=0, SUB=1, PASS=2, ZER=3, MUL4=5, DIV2=6.
- `b_sel` output, 4 bits: B-bus source. 0–7 = R0–R7, 8 = MDR, 9 = AC, 10 = PC.
- `c_we` output, 11 bits, one-hot or zero: C-bus write enables. Bits 0–7 = R0–R7, 8 = AC, 9 = MAR, 10 = MDR.
- `pc_inc` output, 1 bit: PC increment strobe.
- `pc_load` output, 1 bit: PC loads from the C bus.
- `ir_load` output, 1 bit: IR loads from memory data.
- `mem_rd` output, 1 bit: memory read request.
- `mem_wr` output, 1 bit: memory write request.
- `busy` output, 1 bit: high in every state except IDLE and DONE.
- `done` output, 1 bit: high in DONE.

## Operation
- The A bus is always AC. All outputs are decoded from the state and the latched opcode/operand.
- **Defaults** (every state unless overridden): `alu_op`=ZER, `b_sel`=0, `c_we`=0, all strobes 0.
- **States:** IDLE, FETCH, FWAIT, DECODE, EXEC, EXEC2, MWAIT, WB, DONE.
- **IDLE / DONE:** on `start`, go to FETCH.
- **FETCH:** PASS, `b_sel`=PC, `c_we`[MAR]. Go to FWAIT.
- **FWAIT:** `mem_rd`=1. On `mem_ready`, assert `ir_load` and `pc_inc`, then go to DECODE; otherwise stay in FWAIT.
- **DECODE:** latch `instr` into opcode/operand registers. Go to EXEC.
- **EXEC, by opcode** (n = operand register):
  - NOP (0): go to FETCH.
  - LOAD (1), AC←M[Rn]: PASS, `b_sel`=Rn, MAR written. Then MWAIT with `mem_rd`. Then WB: PASS, `b_sel`=MDR, AC written. Then FETCH.
  - STORE (2), M[Rn]←AC: PASS Rn→MAR. Then EXEC2: PASS AC→MDR. Then MWAIT with `mem_wr`. Then FETCH.
  - ADD (3): ADD, `b_sel`=Rn, AC written.
  - SUB (4): SUB, `b_sel`=Rn, AC written, and `z_reg`←`flag_z`.
  - MOV (5), Rn←AC: PASS, `b_sel`=AC, Rn written.
  - CLR (6): ZER, AC written.
  - MUL4 (7): MUL4, AC written.
  - DIV2 (8): DIV2, AC written.
  - JMP (9): PASS, `b_sel`=Rn, `pc_load`.
  - JMPNZ (10): as JMP only when `z_reg`=0; otherwise no strobes.
  - HALT (15): go to DONE.
  - After any single-cycle op above, go to FETCH.
  - Opcodes 11–14 execute as NOP.
- `z_reg` is written only in a SUB EXEC cycle. The flag is meaningful only after SUB, so no other op may update `z_reg`.
- `start` while `busy` is ignored.

## Timing
- Reset values: state=IDLE, `z_reg`=0, `busy`=0, `done`=0, `alu_op`=3, `b_sel`=0, `c_we`=0, all strobes 0.
- Reset mid-operation (including during MWAIT/FWAIT) returns to IDLE at that edge. `mem_rd` and `mem_wr` drop in the same cycle.
- With zero-wait memory (`mem_ready` high in the first FWAIT/MWAIT cycle):
  - ALU/JMP/NOP ops: 4 cycles, start of FETCH to next FETCH.
  - LOAD and STORE: 6 cycles.
  - Each extra wait cycle adds 1.
- `mem_rd`/`mem_wr` are held high and constant until the cycle `mem_ready` is sampled high.
- `mem_ready` outside FWAIT/MWAIT is ignored.
- `done` rises one cycle after HALT's EXEC and holds until `start` or reset.

## Structure
- Package `ctrl_pkg` holds:
  - ALU op constants;
  - opcode constants;
  - state enum;
  - `b_sel` and `c_we` index constants.
- One sub-module `ctrl_decode` (combinational): maps state, opcode, operand and `z_reg` to the control word. The top holds the FSM, opcode/operand registers and `z_reg`.

## Test plan
- Reset, then `start` with instr=0x35 and no waits: FETCH→FWAIT→DECODE→EXEC. In EXEC, `alu_op`=0, `b_sel`=5, `c_we`=0x100. Next state FETCH.
- SUB (0x42) with `flag_z`=1, then JMPNZ (0xA1): `pc_load` stays 0. Repeat with `flag_z`=0: `pc_load`=1 with `b_sel`=1.
- LOAD 0x13 with `mem_ready` delayed 3 cycles: `mem_rd` held 3 cycles in MWAIT. WB gives `b_sel`=8, `c_we`=0x100. Total 8 cycles.
- STORE 0x27: EXEC `c_we`=0x200; EXEC2 `b_sel`=9, `c_we`=0x400; MWAIT `mem_wr`=1.
- HALT 0xF0: `done`=1 and `busy`=0 held. `start` restarts at FETCH. Opcode 0xC0 behaves as NOP.
- `rst_n`=0 during FWAIT: next cycle IDLE, `mem_rd`=0, `z_reg`=0.
